seq_accum_cpu: RTL and testbench

Parametrised successor to the fixed 4-bit datapath: a small multicycle accumulator CPU with a writable program store, parametrised data width and program depth, and an explicit run/halt state machine. Instructions are an opcode plus an immediate. They drive X (operand), Y (accumulator) and Z (display) registers through a shared adder/shifter, and carry/borrow is reported. The block sits at the top of the datapath and is loaded and started by a testbench or host.

---
 rtl/seq_cpu_pkg.sv | 28 ++
 rtl/seq_accum_cpu_prog_mem.sv | 30 +++
 rtl/seq_accum_cpu.sv | 157 +++++++++++++++
 tb/tb_seq_accum_cpu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_cpu_pkg.sv
// Shared definitions for the sequential accumulator CPU: opcodes, FSM states
// and instruction field layout.
package seq_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_CLRLD = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADDLD = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd2;
    localparam logic [OPC_W-1:0] OP_SHR   = 4'd3;
    localparam logic [OPC_W-1:0] OP_SHL   = 4'd4;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd5;
    localparam logic [OPC_W-1:0] OP_DISP  = 4'd6;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALTED
    } cpuState_e;

    // The opcode sits directly above the immediate, so its LSB equals the data width.
    function automatic int opcLsb(input int dataW);
        return dataW;
    endfunction

endpackage

// File: rtl/seq_accum_cpu_prog_mem.sv
// Program store: synchronous write, registered read, contents never reset.
module prog_mem #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 12,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] memQ [DEPTH];
    logic [WORD_W-1:0] rdataQ;

    always_ff @(posedge clk) begin
        if (we_i) begin
            memQ[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdataQ <= memQ[raddr_i];
        end
    end

    assign rdata_o = rdataQ;

endmodule

// File: rtl/seq_accum_cpu.sv
// Multicycle accumulator CPU: FETCH/EXEC sequencer around a writable program
// store, with X/Y/Z registers sharing one adder/subtractor/shifter.
module seq_accum_cpu
    import seq_cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  prog_we_i,
    input  logic [ADDR_W-1:0]     prog_addr_i,
    input  logic [OPC_W+DATA_W-1:0] prog_wdata_i,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic [DATA_W-1:0]     out_o,
    output logic                  out_valid_o,
    output logic                  carry_o,
    output logic [ADDR_W-1:0]     pc_o
);

    localparam int OPC_LSB = opcLsb(DATA_W);
    localparam int WORD_W  = OPC_W + DATA_W;

    cpuState_e         stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic [DATA_W-1:0] xQ, xD, yQ, yD, zQ, zD;
    logic              carryQ, carryD;
    logic              outValidQ, outValidD;

    logic [WORD_W-1:0] instr;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W:0]   sum, diff;
    logic              busy;

    assign busy = (stateQ == ST_FETCH) || (stateQ == ST_EXEC);

    prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (prog_we_i && !busy),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_wdata_i),
        .re_i    (stateQ == ST_FETCH),
        .raddr_i (pcQ),
        .rdata_o (instr)
    );

    assign opcode = instr[OPC_LSB +: OPC_W];
    assign imm    = instr[DATA_W-1:0];
    // The extra top bit of the sum is the carry-out; of the difference, the borrow.
    assign sum    = {1'b0, yQ} + {1'b0, xQ};
    assign diff   = {1'b0, yQ} - {1'b0, xQ};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= ST_IDLE;
            pcQ       <= '0;
            xQ        <= '0;
            yQ        <= '0;
            zQ        <= '0;
            carryQ    <= 1'b0;
            outValidQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            xQ        <= xD;
            yQ        <= yD;
            zQ        <= zD;
            carryQ    <= carryD;
            outValidQ <= outValidD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        xD        = xQ;
        yD        = yQ;
        zD        = zQ;
        carryD    = carryQ;
        outValidD = 1'b0;
        unique case (stateQ)
            ST_IDLE, ST_HALTED: begin
                if (start_i) begin
                    stateD = ST_FETCH;
                    pcD    = '0;
                    xD     = '0;
                    yD     = '0;
                    zD     = '0;
                    carryD = 1'b0;
                end
            end
            ST_FETCH: begin
                stateD = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_CLRLD: begin
                        xD     = imm;
                        yD     = '0;
                        zD     = '0;
                        carryD = 1'b0;
                    end
                    OP_ADDLD: begin
                        yD     = sum[DATA_W-1:0];
                        carryD = sum[DATA_W];
                        xD     = imm;
                    end
                    OP_ADD: begin
                        yD     = sum[DATA_W-1:0];
                        carryD = sum[DATA_W];
                    end
                    OP_SHR: begin
                        yD     = yQ >> 1;
                        carryD = yQ[0];
                    end
                    OP_SHL: begin
                        yD     = yQ << 1;
                        carryD = yQ[DATA_W-1];
                    end
                    OP_SUB: begin
                        yD     = diff[DATA_W-1:0];
                        carryD = diff[DATA_W];
                    end
                    OP_DISP: begin
                        zD        = yQ;
                        outValidD = 1'b1;
                    end
                    default: ;
                endcase
                // The last address halts in place rather than wrapping to 0.
                if (opcode == OP_HALT || pcQ == ADDR_W'(PROG_DEPTH - 1)) begin
                    stateD = ST_HALTED;
                end else begin
                    stateD = ST_FETCH;
                    pcD    = pcQ + ADDR_W'(1);
                end
            end
            default: stateD = ST_IDLE;
        endcase
    end

    assign busy_o      = busy;
    assign halted_o    = (stateQ == ST_HALTED);
    assign out_o       = zQ;
    assign out_valid_o = outValidQ;
    assign carry_o     = carryQ;
    assign pc_o        = pcQ;

endmodule

// File: tb/tb_seq_accum_cpu.sv
// Randomised and directed bench for seq_accum_cpu, checked against an
// instruction-level interpreter of the program.
module tb_seq_accum_cpu;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              startIn = 1'b0;
    logic              progWe = 1'b0;
    logic [AW-1:0]     progAddr = '0;
    logic [11:0]       progWdata = '0;
    logic              busy, halted, outValid, carry;
    logic [DATA_W-1:0] outVal;
    logic [AW-1:0]     pc;

    int vectorCount = 0;
    int miscompareCount = 0;

    logic [11:0] progModel [DEPTH];
    int          expLen, mx, my, mz, mc;
    bit          dispAt [DEPTH];
    int          dispVal [DEPTH];

    seq_accum_cpu #(.DATA_W(DATA_W), .PROG_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (startIn),
        .prog_we_i    (progWe),
        .prog_addr_i  (progAddr),
        .prog_wdata_i (progWdata),
        .busy_o       (busy),
        .halted_o     (halted),
        .out_o        (outVal),
        .out_valid_o  (outValid),
        .carry_o      (carry),
        .pc_o         (pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] mkInstr(input int op, input int imm);
        return {4'(op), 8'(imm)};
    endfunction

    // Interpret the program one instruction at a time on plain integers.
    task automatic modelRun();
        int  op, imm, t;
        bit  done;
        mx = 0; my = 0; mz = 0; mc = 0; expLen = DEPTH; done = 0;
        for (int k = 0; k < DEPTH; k++) begin
            dispAt[k] = 0;
            dispVal[k] = 0;
        end
        for (int k = 0; k < DEPTH && !done; k++) begin
            op  = int'(progModel[k][11:8]);
            imm = int'(progModel[k][7:0]);
            case (op)
                0: begin mx = imm; my = 0; mz = 0; mc = 0; end
                1: begin t = my + mx; mc = (t >= 256) ? 1 : 0; my = t % 256; mx = imm; end
                2: begin t = my + mx; mc = (t >= 256) ? 1 : 0; my = t % 256; end
                3: begin mc = my % 2; my = my / 2; end
                4: begin mc = (my >= 128) ? 1 : 0; my = (my * 2) % 256; end
                5: begin mc = (mx > my) ? 1 : 0; my = (my - mx + 256) % 256; end
                6: begin mz = my; dispAt[k] = 1; dispVal[k] = my; end
                default: ;
            endcase
            if (op == 7 || k == DEPTH - 1) begin
                expLen = k + 1;
                done = 1;
            end
        end
    endtask

    task automatic applyStimulus();
        for (int a = 0; a < DEPTH; a++) begin
            progWe = 1'b1;
            progAddr = AW'(a);
            progWdata = progModel[a];
            tick();
        end
        progWe = 1'b0;
    endtask

    task automatic fillNops();
        for (int a = 0; a < DEPTH; a++) progModel[a] = mkInstr(8 + (a % 8), a);
    endtask

    // Start the loaded program and check every cycle through to HALTED.
    task automatic runChecked(input int pokeWeAt, input int pokeStartAt, input bit writeWithStart, input logic [11:0] word0);
        int k, expPc;
        if (writeWithStart) progModel[0] = word0;
        modelRun();
        startIn = 1'b1;
        if (writeWithStart) begin
            progWe = 1'b1;
            progAddr = '0;
            progWdata = word0;
        end
        tick();
        startIn = 1'b0;
        progWe = 1'b0;
        checkOutput("busyAfterStart", busy, 1);
        checkOutput("pcAfterStart", pc, 0);
        for (int c = 1; c <= 2 * expLen; c++) begin
            if (c == pokeWeAt) begin
                progWe = 1'b1;
                progAddr = '0;
                progWdata = ~progModel[0];
            end
            if (c == pokeStartAt) startIn = 1'b1;
            tick();
            progWe = 1'b0;
            startIn = 1'b0;
            k = (c - 1) / 2;
            expPc = ((c % 2) == 1 || c == 2 * expLen) ? k : k + 1;
            checkOutput("pc", pc, expPc);
            checkOutput("outValid", outValid, ((c % 2) == 0 && dispAt[k]) ? 1 : 0);
            if ((c % 2) == 0 && dispAt[k]) checkOutput("dispOut", outVal, dispVal[k]);
            checkOutput("halted", halted, (c == 2 * expLen) ? 1 : 0);
            checkOutput("busy", busy, (c == 2 * expLen) ? 0 : 1);
        end
        checkOutput("finalOut", outVal, mz);
        checkOutput("finalCarry", carry, mc);
        checkOutput("finalX", dut.xQ, mx);
        checkOutput("finalY", dut.yQ, my);
        tick();
        checkOutput("haltedHold", halted, 1);
        checkOutput("noStrayValid", outValid, 0);
    endtask

    task automatic loadFirstProgram();
        fillNops();
        progModel[0] = mkInstr(0, 4);
        progModel[1] = mkInstr(1, 2);
        progModel[2] = mkInstr(2, 0);
        progModel[3] = mkInstr(3, 0);
        progModel[4] = mkInstr(6, 0);
        progModel[5] = mkInstr(7, 0);
        applyStimulus();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Busy"}, busy, 0);
        checkOutput({tag, "Halted"}, halted, 0);
        checkOutput({tag, "Pc"}, pc, 0);
        checkOutput({tag, "Out"}, outVal, 0);
        checkOutput({tag, "Valid"}, outValid, 0);
        checkOutput({tag, "Carry"}, carry, 0);
    endtask

    initial begin
        #3;
        checkResetOutputs("reset");
        #2 rst = 1'b0;
        tick();

        loadFirstProgram();
        runChecked(0, 0, 0, '0);
        checkOutput("firstOut", outVal, 3);
        checkOutput("firstPc", pc, 5);

        fillNops();
        progModel[0] = mkInstr(0, 200);
        progModel[1] = mkInstr(1, 100);
        progModel[2] = mkInstr(2, 0);
        progModel[3] = mkInstr(6, 0);
        progModel[4] = mkInstr(7, 0);
        applyStimulus();
        runChecked(0, 0, 0, '0);
        checkOutput("wrapOut", outVal, 44);

        fillNops();
        progModel[0] = mkInstr(0, 5);
        progModel[1] = mkInstr(2, 0);
        progModel[2] = mkInstr(5, 0);
        progModel[3] = mkInstr(5, 0);
        progModel[4] = mkInstr(6, 0);
        progModel[5] = mkInstr(7, 0);
        applyStimulus();
        runChecked(0, 0, 0, '0);
        checkOutput("borrowOut", outVal, 251);

        fillNops();
        applyStimulus();
        runChecked(0, 0, 0, '0);
        checkOutput("nopPc", pc, 15);

        loadFirstProgram();
        startIn = 1'b1;
        tick();
        startIn = 1'b0;
        repeat (7) tick();
        #2 rst = 1'b1;
        #1 checkResetOutputs("midReset");
        #1 rst = 1'b0;
        tick();
        runChecked(0, 0, 0, '0);
        checkOutput("retainedOut", outVal, 3);

        runChecked(3, 0, 0, '0);
        runChecked(0, 5, 0, '0);
        checkOutput("busyWriteIgnored", outVal, 3);

        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        runChecked(0, 0, 1, mkInstr(0, 9));
        checkOutput("writeStartOut", outVal, 5);

        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                progModel[a] = mkInstr(($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 15), $urandom_range(0, 255));
            end
            progModel[0] = mkInstr(0, $urandom_range(0, 255));
            applyStimulus();
            runChecked(($urandom_range(0, 1) == 1) ? 2 : 0, ($urandom_range(0, 1) == 1) ? 1 : 0, 0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
